// File: rtl/zorro_intctl.sv
// Zorro III interrupt controller: synced sources, pending/enable/route regs, INT2/INT6 requests, quick-int vectors.
// dtack DTACK_DELAY clks after strobe qualification; held until FCS_n rises; FCS_n high before dtack aborts the cycle.
module zorro_intctl #(
  parameter int                 NUM_SRC     = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 DTACK_DELAY = 2
) (
  input  logic               clk,
  input  logic               IORST_n,
  input  logic               reg_cycle,
  input  logic [1:0]         reg_addr,
  input  logic               FCS_n,
  input  logic               DOE,
  input  logic               DS0_n,
  input  logic               READ,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               data_oe,
  output logic               dtack,
  input  logic [NUM_SRC-1:0] src_n,
  output logic               int2_sig,
  output logic               int6_sig,
  input  logic               quickint_cycle,
  input  logic               quickint_level,
  output logic               slave
);

  localparam int CW = (DTACK_DELAY > 1) ? $clog2(DTACK_DELAY) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_act_d;
  logic [NUM_SRC-1:0] r_epend;
  logic [NUM_SRC-1:0] r_en;
  logic [NUM_SRC-1:0] r_lvl;
  logic [7:0]         r_vec;
  logic               r_int2;
  logic               r_int6;
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_ack;
  logic               r_is_read;
  logic [1:0]         r_addr;
  logic [2:0]         r_win;

  logic [NUM_SRC-1:0] w_act;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_match_hi;
  logic [NUM_SRC-1:0] w_match_lo;
  logic [NUM_SRC-1:0] w_sel;
  logic [NUM_SRC-1:0] w_win_oh;
  logic [NUM_SRC-1:0] w_clr;
  logic [2:0]         w_win;
  logic               w_win_vld;
  logic               w_ack_start;
  logic               w_reg_start;
  logic               w_commit;
  logic               w_ack_done;
  logic               w_busy;
  state_t             w_next;

  // Sync chain stores the active-high sense so reset (all 0) means "inactive".
  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_act_d <= '0;
    end else begin
      r_sync[0] <= ~src_n;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_act_d <= w_act;
    end
  end

  assign w_act      = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_act & ~r_act_d;
  assign w_pend     = (w_act & ~EDGE_MASK) | (r_epend & EDGE_MASK);
  assign w_match_hi = w_pend & r_en & r_lvl;
  assign w_match_lo = w_pend & r_en & ~r_lvl;
  assign w_sel      = quickint_level ? w_match_hi : w_match_lo;

  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        w_win     = 3'(i);
        w_win_vld = 1'b1;
      end
    end
  end

  assign w_ack_start = quickint_cycle & ~FCS_n & w_win_vld;
  assign w_reg_start = reg_cycle & ~FCS_n & DOE & ~DS0_n;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_commit    = (r_state == ST_ACK) & ~r_is_ack & ~r_is_read;
  assign w_ack_done  = (r_state == ST_HOLD) & FCS_n & r_is_ack;
  assign w_win_oh    = NUM_SRC'(1) << r_win;
  assign w_clr       = ((w_commit && r_addr == 2'd0) ? din[NUM_SRC-1:0] : '0) |
                       (w_ack_done ? w_win_oh : '0);

  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_ack_start || w_reg_start) w_next = ST_WAIT;
      ST_WAIT: begin
        if (FCS_n)                                 w_next = ST_IDLE;
        else if (r_cnt == CW'(DTACK_DELAY - 1))    w_next = ST_ACK;
      end
      ST_ACK:  w_next = ST_HOLD;
      ST_HOLD: if (FCS_n) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Cycle context, including the ack winner, is frozen at WAIT entry.
  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      r_cnt     <= '0;
      r_is_ack  <= 1'b0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_win     <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
      if (w_ack_start || w_reg_start) begin
        r_is_ack  <= w_ack_start;
        r_is_read <= READ & ~w_ack_start;
        r_addr    <= reg_addr;
        r_win     <= w_win;
      end
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      r_en    <= '0;
      r_lvl   <= '0;
      r_vec   <= 8'h0F;
      r_epend <= '0;
      r_int2  <= 1'b0;
      r_int6  <= 1'b0;
    end else begin
      if (w_commit) begin
        case (r_addr)
          2'd1:    r_en  <= din[NUM_SRC-1:0];
          2'd2:    r_lvl <= din[NUM_SRC-1:0];
          2'd3:    r_vec <= din;
          default: ;
        endcase
      end
      // A new edge in the same clock as a clear keeps the bit pending.
      r_epend <= ((r_epend & ~w_clr) | w_rise) & EDGE_MASK;
      r_int2  <= |w_match_lo;
      r_int6  <= |w_match_hi;
    end
  end

  assign int2_sig = r_int2;
  assign int6_sig = r_int6;
  assign dtack    = (r_state == ST_ACK) || (r_state == ST_HOLD);
  assign slave    = w_busy & r_is_ack;
  assign data_oe  = w_busy & (r_is_ack | r_is_read);

  always_comb begin
    dout = 8'h00;
    if (data_oe) begin
      if (r_is_ack) begin
        dout = {r_vec[7:3], r_win};
      end else begin
        case (r_addr)
          2'd0:    dout = 8'(w_pend);
          2'd1:    dout = 8'(r_en);
          2'd2:    dout = 8'(r_lvl);
          default: dout = r_vec;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zorro_intctl.sv
// Directed bench for zorro_intctl: register table, source paths, quick-int acks, abort and reset corners.
module tb_zorro_intctl;

  logic       clk = 1'b0;
  logic       IORST_n = 1'b0;
  logic       reg_cycle = 1'b0;
  logic [1:0] reg_addr = 2'd0;
  logic       FCS_n = 1'b1;
  logic       DOE = 1'b0;
  logic       DS0_n = 1'b1;
  logic       READ = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       data_oe;
  logic       dtack;
  logic [3:0] src_n = 4'hF;
  logic       int2_sig;
  logic       int6_sig;
  logic       quickint_cycle = 1'b0;
  logic       quickint_level = 1'b0;
  logic       slave;

  int n_chk = 0;
  int n_fail = 0;

  zorro_intctl #(
    .NUM_SRC(4), .EDGE_MASK(4'b0100), .SYNC_STAGES(2), .DTACK_DELAY(2)
  ) dut (
    .clk(clk), .IORST_n(IORST_n), .reg_cycle(reg_cycle), .reg_addr(reg_addr),
    .FCS_n(FCS_n), .DOE(DOE), .DS0_n(DS0_n), .READ(READ), .din(din),
    .dout(dout), .data_oe(data_oe), .dtack(dtack), .src_n(src_n),
    .int2_sig(int2_sig), .int6_sig(int6_sig), .quickint_cycle(quickint_cycle),
    .quickint_level(quickint_level), .slave(slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h required 0x%02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctl();
    return {5'b0, slave, dtack, data_oe};
  endfunction

  task automatic wait_dtack(input string name);
    int t = 0;
    while (dtack !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (dtack !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got dtack=%b required 1 within 20 clk", name, dtack);
    end
  endtask

  task automatic bus(input logic rd, input logic [1:0] a, input logic [7:0] wd, output logic [7:0] rdat);
    @(negedge clk);
    reg_cycle = 1'b1; reg_addr = a; READ = rd; din = wd; DOE = 1'b1; DS0_n = 1'b0; FCS_n = 1'b0;
    @(negedge clk);
    wait_dtack("bus");
    rdat = dout;
    @(negedge clk);
    FCS_n = 1'b1; DS0_n = 1'b1; DOE = 1'b0; reg_cycle = 1'b0; READ = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] v;
    bus(1'b0, a, d, v);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    bus(1'b1, a, 8'h00, v);
    check(name, v, exp);
  endtask

  typedef struct {
    logic       rd;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] v;

    tbl[0] = '{1'b0, 2'd1, 8'hFF, 8'h00};
    tbl[1] = '{1'b1, 2'd1, 8'h00, 8'h0F};
    tbl[2] = '{1'b0, 2'd2, 8'hA5, 8'h00};
    tbl[3] = '{1'b1, 2'd2, 8'h00, 8'h05};
    tbl[4] = '{1'b0, 2'd3, 8'h40, 8'h00};
    tbl[5] = '{1'b1, 2'd3, 8'h00, 8'h40};
    tbl[6] = '{1'b1, 2'd0, 8'h00, 8'h00};
    tbl[7] = '{1'b0, 2'd1, 8'h00, 8'h00};
    tbl[8] = '{1'b1, 2'd1, 8'h00, 8'h00};
    tbl[9] = '{1'b0, 2'd2, 8'h00, 8'h00};

    // Reset state.
    #12;
    check("rst_ctl", ctl(), 8'h00);
    check("rst_dout", dout, 8'h00);
    check("rst_ints", {6'b0, int2_sig, int6_sig}, 8'h00);
    @(negedge clk);
    IORST_n = 1'b1;
    rd_chk("rst_enable", 2'd1, 8'h00);
    rd_chk("rst_level", 2'd2, 8'h00);
    rd_chk("rst_vector", 2'd3, 8'h0F);
    rd_chk("rst_status", 2'd0, 8'h00);

    for (int i = 0; i < 10; i++) begin
      bus(tbl[i].rd, tbl[i].a, tbl[i].d, v);
      if (tbl[i].rd) check($sformatf("tbl%0d", i), v, tbl[i].exp);
    end

    // Level source 1 routed to INT2.
    wr(2'd1, 8'h02);
    wr(2'd2, 8'h00);
    @(negedge clk);
    src_n[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("lvl_int2_early", {7'b0, int2_sig}, 8'h00);
    @(negedge clk);
    check("lvl_int2_on", {7'b0, int2_sig}, 8'h01);
    rd_chk("lvl_status", 2'd0, 8'h02);
    wr(2'd0, 8'h02);
    rd_chk("lvl_w1c_ignored", 2'd0, 8'h02);
    src_n[1] = 1'b1;
    repeat (4) @(negedge clk);
    check("lvl_int2_off", {7'b0, int2_sig}, 8'h00);
    rd_chk("lvl_status_off", 2'd0, 8'h00);

    // Edge source 2: latched after a 3-clk pulse, cleared by W1C.
    wr(2'd1, 8'h04);
    @(negedge clk);
    src_n[2] = 1'b0;
    repeat (3) @(negedge clk);
    src_n[2] = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("edge_status", 2'd0, 8'h04);
    check("edge_int2", {7'b0, int2_sig}, 8'h01);
    repeat (5) @(negedge clk);
    rd_chk("edge_status_stays", 2'd0, 8'h04);
    wr(2'd0, 8'h04);
    rd_chk("edge_w1c", 2'd0, 8'h00);
    repeat (2) @(negedge clk);
    check("edge_int2_off", {7'b0, int2_sig}, 8'h00);

    // Edge set lands on the same clock as the W1C commit: set wins.
    @(negedge clk);
    reg_cycle = 1'b1; reg_addr = 2'd0; READ = 1'b0; din = 8'h04; DOE = 1'b1; DS0_n = 1'b0; FCS_n = 1'b0;
    @(negedge clk);
    src_n[2] = 1'b0;
    @(negedge clk);
    check("sw_no_dtack_yet", {7'b0, dtack}, 8'h00);
    @(negedge clk);
    check("sw_dtack", {7'b0, dtack}, 8'h01);
    @(negedge clk);
    FCS_n = 1'b1; DS0_n = 1'b1; DOE = 1'b0; reg_cycle = 1'b0;
    @(negedge clk);
    src_n[2] = 1'b1;
    rd_chk("set_wins", 2'd0, 8'h04);
    wr(2'd0, 8'h04);
    rd_chk("set_wins_cleanup", 2'd0, 8'h00);

    // FCS_n rises during WAIT: write aborted.
    wr(2'd1, 8'h01);
    @(negedge clk);
    reg_cycle = 1'b1; reg_addr = 2'd1; READ = 1'b0; din = 8'h05; DOE = 1'b1; DS0_n = 1'b0; FCS_n = 1'b0;
    @(negedge clk);
    FCS_n = 1'b1; DS0_n = 1'b1; DOE = 1'b0; reg_cycle = 1'b0;
    @(negedge clk);
    check("abort_ctl", ctl(), 8'h00);
    repeat (3) @(negedge clk);
    check("abort_ctl_late", ctl(), 8'h00);
    rd_chk("abort_enable", 2'd1, 8'h01);

    // Sources 1 and 3 on INT6.
    wr(2'd3, 8'h40);
    wr(2'd1, 8'h0A);
    wr(2'd2, 8'h0A);
    src_n[1] = 1'b0;
    src_n[3] = 1'b0;
    repeat (4) @(negedge clk);
    check("ack_ints", {6'b0, int2_sig, int6_sig}, 8'h01);

    // Ack INT2 with nothing routed there: no response at all.
    @(negedge clk);
    quickint_cycle = 1'b1; quickint_level = 1'b0; FCS_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("noack_ctl%0d", i), ctl(), 8'h00);
    end
    FCS_n = 1'b1; quickint_cycle = 1'b0;
    @(negedge clk);

    // Ack INT6: winner source 1.
    quickint_cycle = 1'b1; quickint_level = 1'b1; FCS_n = 1'b0;
    @(negedge clk);
    check("ack6_wait_ctl", ctl(), 8'h05);
    check("ack6_wait_dout", dout, 8'h41);
    @(negedge clk);
    check("ack6_wait2_ctl", ctl(), 8'h05);
    @(negedge clk);
    check("ack6_ack_ctl", ctl(), 8'h07);
    check("ack6_ack_dout", dout, 8'h41);
    @(negedge clk);
    check("ack6_hold_ctl", ctl(), 8'h07);
    FCS_n = 1'b1; quickint_cycle = 1'b0;
    @(negedge clk);
    check("ack6_release_ctl", ctl(), 8'h00);
    rd_chk("ack6_level_kept", 2'd0, 8'h0A);

    // Edge winner on INT6 is cleared when the ack cycle ends.
    src_n[1] = 1'b1;
    wr(2'd1, 8'h0C);
    wr(2'd2, 8'h0C);
    @(negedge clk);
    src_n[2] = 1'b0;
    repeat (3) @(negedge clk);
    src_n[2] = 1'b1;
    repeat (4) @(negedge clk);
    quickint_cycle = 1'b1; quickint_level = 1'b1; FCS_n = 1'b0;
    @(negedge clk);
    wait_dtack("ack_edge");
    check("ack_edge_dout", dout, 8'h42);
    FCS_n = 1'b1; quickint_cycle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd_chk("ack_edge_cleared", 2'd0, 8'h08);
    src_n[3] = 1'b1;

    // Reset asserted mid-HOLD of a write.
    @(negedge clk);
    reg_cycle = 1'b1; reg_addr = 2'd1; READ = 1'b0; din = 8'h03; DOE = 1'b1; DS0_n = 1'b0; FCS_n = 1'b0;
    @(negedge clk);
    wait_dtack("rst_hold");
    @(negedge clk);
    check("rst_hold_dtack", {7'b0, dtack}, 8'h01);
    #2;
    IORST_n = 1'b0;
    #1;
    check("rst_hold_ctl", ctl(), 8'h00);
    check("rst_hold_dout", dout, 8'h00);
    @(negedge clk);
    FCS_n = 1'b1; DS0_n = 1'b1; DOE = 1'b0; reg_cycle = 1'b0;
    @(negedge clk);
    IORST_n = 1'b1;
    rd_chk("rst_hold_enable", 2'd1, 8'h00);
    rd_chk("rst_hold_vector", 2'd3, 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
